sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6: SRAM word address width.
REQ-002 Parameter DATA_W, default 8: SRAM data width.
REQ-003 Port wb_clk_i, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 Port wb_rst_i, input, 1: reset, synchronous and active-high.
REQ-005 Port en, input, 2: per-requester enable (bit 0 = qcpu, bit 1 = mc14500); a disabled requester's req is ignored.
REQ-006 Port prio_fixed, input, 1: 1 = fixed priority with requester 0 highest; 0 = round-robin.
REQ-007 Ports req[i], we[i] (input, 1 each), addr[i] (input, ADDR_W) and wdata[i] (input, DATA_W), for i = 0..1: the request channel.
REQ-008 Ports gnt[i] (output, 1), rvalid[i] (output, 1) and rdata[i] (output, DATA_W), for i = 0..1: the response channel.
REQ-009 Port sram_cen, output, 1: active-low macro chip enable.
REQ-010 Port sram_gwe, output, 1: active-low macro global write enable.
REQ-011 Ports sram_addr (output, ADDR_W), sram_din (output, DATA_W) and sram_dout (input, DATA_W): the macro address, write data and read data.

Function
REQ-012 The block SHALL arbitrate one shared 64x8 SRAM macro between two requesters, issuing at most one macro access per cycle.
REQ-013 An eligible requester SHALL have req=1 and its en bit=1, and SHALL NOT have its gnt=1 in the current cycle.
- A requester is therefore never granted on two consecutive cycles.
REQ-014 Arbitration SHALL be evaluated in cycle N; the winner's gnt SHALL be high for exactly one cycle, in cycle N+1.
REQ-015 In cycle N+1 the block SHALL drive sram_cen=0, sram_addr=winner addr and sram_gwe=~winner we, all from registers.
- sram_din SHALL equal the winner's wdata when we=1.
REQ-016 With no access, sram_cen and sram_gwe SHALL be 1, and sram_addr/sram_din SHALL hold their last values.
REQ-017 For a read granted in N+1, rvalid[i] SHALL be high for one cycle in N+2 with rdata[i]=sram_dout; writes SHALL produce no rvalid.
REQ-018 rdata[i] SHALL hold its value until the next rvalid[i].
REQ-019 Requesters SHALL hold req/we/addr/wdata stable from assertion until gnt; the block captures them at the arbitration edge.
REQ-020 Round-robin on a conflict: the requester that is not last_winner SHALL win; on a single eligible request, that requester SHALL win.
REQ-021 last_winner SHALL update on every grant.
REQ-022 prio_fixed=1: requester 0 SHALL win every conflict; last_winner still updates.
REQ-023 Clearing en[i] after arbitration SHALL NOT cancel the issued gnt/rvalid already in flight.
REQ-024 Aggregate throughput SHALL be one access per cycle when both requesters alternate; a single requester SHALL achieve one access per 2 cycles.

Reset
REQ-025 While wb_rst_i=1 at a clock edge, the following SHALL be forced on the next cycle and any in-flight access discarded:
- gnt, rvalid and rdata: 0;
- sram_cen and sram_gwe: 1;
- sram_addr and sram_din: 0;
- last_winner: 1, so requester 0 wins the first conflict.
REQ-026 Outputs SHALL be valid from the first cycle after wb_rst_i falls.
- A reset asserted in the gnt cycle SHALL suppress the corresponding rvalid.

Structure
REQ-027 Package sram_arb_pkg SHALL hold:
- ADDR_W and DATA_W defaults;
- requester index constants REQ_QCPU=0 and REQ_MC14500=1.
REQ-028 Winner selection SHALL be a combinational sub-module sram_arb_pick (eligible[1:0], last_winner, prio_fixed -> valid, winner); all remaining logic is registered in sram_arbiter.

Verification
REQ-029 Read: reset, then req0 read addr 0x05 with macro holding 0xA5 -> gnt0 at N+1, sram_cen=0, sram_gwe=1, sram_addr=0x05; rvalid0 at N+2 with rdata0=0xA5.
REQ-030 Write: req1 write addr 0x3F, data 0x5A -> gnt1 at N+1, sram_gwe=0, sram_din=0x5A; no rvalid1; a subsequent read of 0x3F returns 0x5A.
REQ-031 Round-robin: both req held continuously, prio_fixed=0 -> grants 0,1,0,1... every cycle; after reset the first grant is to requester 0.
REQ-032 Fixed priority: prio_fixed=1, both req held -> requester 0 granted every other cycle, requester 1 granted only in the cycles where requester 0 is ineligible.
REQ-033 Enable/reset: en=2'b10 with req0 held -> no gnt0. Separately, wb_rst_i asserted in a read's gnt cycle -> no rvalid, and sram_cen=1 the next cycle.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared constants for the two-requester SRAM arbiter: default macro geometry
// and requester indices.
package sram_arb_pkg;

  localparam int ADDR_W_DEFAULT = 6;
  localparam int DATA_W_DEFAULT = 8;

  localparam int NUM_REQ     = 2;
  localparam int REQ_QCPU    = 0;
  localparam int REQ_MC14500 = 1;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection between the two eligible requesters:
// fixed priority favours qcpu, round-robin favours whoever did not win last.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       last_winner,
  input  logic       prio_fixed,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |eligible;
    winner = 1'(REQ_QCPU);
    case (eligible)
      2'b01:   winner = 1'(REQ_QCPU);
      2'b10:   winner = 1'(REQ_MC14500);
      2'b11:   winner = prio_fixed ? 1'(REQ_QCPU) : ~last_winner;
      default: winner = 1'(REQ_QCPU);
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one single-port SRAM macro between qcpu (0) and mc14500 (1).
// Grant and macro controls are registered one cycle after arbitration; read data returns the cycle after that.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic [1:0]             en,
  input  logic                   prio_fixed,
  input  logic [1:0]             req,
  input  logic [1:0]             we,
  input  logic [1:0][ADDR_W-1:0] addr,
  input  logic [1:0][DATA_W-1:0] wdata,
  output logic [1:0]             gnt,
  output logic [1:0]             rvalid,
  output logic [1:0][DATA_W-1:0] rdata,
  output logic                   sram_cen,
  output logic                   sram_gwe,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [DATA_W-1:0]      sram_din,
  input  logic [DATA_W-1:0]      sram_dout
);

  logic [1:0]             gnt_q, gnt_d;
  logic [1:0]             rd_pend_q, rd_pend_d;
  logic [1:0]             rvalid_q, rvalid_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;
  logic                   cen_q, cen_d;
  logic                   gwe_q, gwe_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      din_q, din_d;
  logic                   last_winner_q, last_winner_d;

  logic [1:0] eligible;
  logic       pick_valid;
  logic       pick_winner;

  // A requester granted this cycle sits out the next arbitration.
  assign eligible = req & en & ~gnt_q;

  sram_arb_pick u_pick (
    .eligible    (eligible),
    .last_winner (last_winner_q),
    .prio_fixed  (prio_fixed),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

  always_comb begin
    gnt_d         = '0;
    rd_pend_d     = '0;
    rvalid_d      = rd_pend_q;
    rdata_d       = rdata_q;
    cen_d         = 1'b1;
    gwe_d         = 1'b1;
    addr_d        = addr_q;
    din_d         = din_q;
    last_winner_d = last_winner_q;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (rvalid_q[i]) rdata_d[i] = sram_dout;
    end

    if (pick_valid) begin
      gnt_d[pick_winner] = 1'b1;
      cen_d              = 1'b0;
      gwe_d              = ~we[pick_winner];
      addr_d             = addr[pick_winner];
      last_winner_d      = pick_winner;
      if (we[pick_winner]) din_d = wdata[pick_winner];
      else                 rd_pend_d[pick_winner] = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      gnt_q         <= '0;
      rd_pend_q     <= '0;
      rvalid_q      <= '0;
      rdata_q       <= '0;
      cen_q         <= 1'b1;
      gwe_q         <= 1'b1;
      addr_q        <= '0;
      din_q         <= '0;
      last_winner_q <= 1'b1;
    end else begin
      gnt_q         <= gnt_d;
      rd_pend_q     <= rd_pend_d;
      rvalid_q      <= rvalid_d;
      rdata_q       <= rdata_d;
      cen_q         <= cen_d;
      gwe_q         <= gwe_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      last_winner_q <= last_winner_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign sram_cen  = cen_q;
  assign sram_gwe  = gwe_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;

  // The macro presents read data in the rvalid cycle; pass it through then,
  // and hold the captured copy until the next read for that requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      rdata[i] = rvalid_q[i] ? sram_dout : rdata_q[i];
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural synchronous 64x8 macro.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_sram_arbiter;

  logic            clk;
  logic            rst;
  logic [1:0]      en;
  logic            prio_fixed;
  logic [1:0]      req;
  logic [1:0]      we;
  logic [1:0][5:0] addr;
  logic [1:0][7:0] wdata;
  logic [1:0]      gnt;
  logic [1:0]      rvalid;
  logic [1:0][7:0] rdata;
  logic            sram_cen;
  logic            sram_gwe;
  logic [5:0]      sram_addr;
  logic [7:0]      sram_din;
  logic [7:0]      sram_dout;

  logic            bd_we;
  logic [5:0]      bd_addr;
  logic [7:0]      bd_data;
  logic [7:0]      mem [64];

  int n_checks;
  int n_errors;

  sram_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .en         (en),
    .prio_fixed (prio_fixed),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .sram_cen   (sram_cen),
    .sram_gwe   (sram_gwe),
    .sram_addr  (sram_addr),
    .sram_din   (sram_din),
    .sram_dout  (sram_dout)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous macro model with a backdoor preload port.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (!sram_cen) begin
      if (!sram_gwe) mem[sram_addr] <= sram_din;
      else           sram_dout <= mem[sram_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; en = 2'b11; prio_fixed = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0; sram_dout = '0;
    step(); step();

    check("rst_gnt",    32'(gnt),      0);
    check("rst_rvalid", 32'(rvalid),   0);
    check("rst_rdata0", 32'(rdata[0]), 0);
    check("rst_rdata1", 32'(rdata[1]), 0);
    check("rst_cen",    32'(sram_cen), 1);
    check("rst_gwe",    32'(sram_gwe), 1);
    check("rst_addr",   32'(sram_addr), 0);
    check("rst_din",    32'(sram_din), 0);
    rst = 1'b0;

    // Read of 0x05 by qcpu, macro holding 0xA5
    bd_we = 1'b1; bd_addr = 6'h05; bd_data = 8'hA5; step(); bd_we = 1'b0;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 6'h05; step();
    check("rd_gnt",  32'(gnt), 'h1);
    check("rd_cen",  32'(sram_cen), 0);
    check("rd_gwe",  32'(sram_gwe), 1);
    check("rd_addr", 32'(sram_addr), 'h05);
    req[0] = 1'b0; step();
    check("rd_rvalid",    32'(rvalid), 'h1);
    check("rd_rdata0",    32'(rdata[0]), 'hA5);
    check("rd_gnt_off",   32'(gnt), 0);
    check("rd_cen_idle",  32'(sram_cen), 1);
    check("rd_addr_hold", 32'(sram_addr), 'h05);
    step();
    check("rd_rvalid_off", 32'(rvalid), 0);
    check("rd_rdata_hold", 32'(rdata[0]), 'hA5);

    // Write of 0x5A to 0x3F by mc14500, then read it back
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 6'h3F; wdata[1] = 8'h5A; step();
    check("wr_gnt",  32'(gnt), 'h2);
    check("wr_cen",  32'(sram_cen), 0);
    check("wr_gwe",  32'(sram_gwe), 0);
    check("wr_din",  32'(sram_din), 'h5A);
    check("wr_addr", 32'(sram_addr), 'h3F);
    req[1] = 1'b0; we[1] = 1'b0; step();
    check("wr_no_rvalid", 32'(rvalid), 0);
    check("wr_cen_idle",  32'(sram_cen), 1);
    check("wr_gwe_idle",  32'(sram_gwe), 1);
    check("wr_din_hold",  32'(sram_din), 'h5A);
    req[1] = 1'b1; step();
    check("rb_gnt", 32'(gnt), 'h2);
    check("rb_gwe", 32'(sram_gwe), 1);
    req[1] = 1'b0; step();
    check("rb_rvalid", 32'(rvalid), 'h2);
    check("rb_rdata1", 32'(rdata[1]), 'h5A);
    check("rb_rdata0", 32'(rdata[0]), 'hA5);

    // Reset asserted in a read's gnt cycle
    req[0] = 1'b1; addr[0] = 6'h05; step();
    check("rg_gnt", 32'(gnt), 'h1);
    req[0] = 1'b0; rst = 1'b1; step();
    check("rg_no_rvalid", 32'(rvalid), 0);
    check("rg_cen",       32'(sram_cen), 1);
    check("rg_gnt",       32'(gnt), 0);
    check("rg_rdata0",    32'(rdata[0]), 0);
    rst = 1'b0;

    // qcpu wins once so last_winner is 0 before the next reset
    req[0] = 1'b1; step();
    check("lw_gnt", 32'(gnt), 'h1);
    req[0] = 1'b0; step();
    check("lw_rvalid", 32'(rvalid), 'h1);
    check("lw_rdata0", 32'(rdata[0]), 'hA5);

    // Round-robin from reset: 0,1,0,1,0
    rst = 1'b1; step(); rst = 1'b0;
    check("rr_rst_gnt", 32'(gnt), 0);
    addr[0] = 6'h01; addr[1] = 6'h02; req = 2'b11;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_gnt",  32'(gnt), (k % 2 == 0) ? 'h1 : 'h2);
      check("rr_addr", 32'(sram_addr), (k % 2 == 0) ? 'h01 : 'h02);
      if (k > 0) check("rr_rvalid", 32'(rvalid), (k % 2 == 0) ? 'h2 : 'h1);
    end
    req = 2'b00; step();
    check("rr_gnt_off", 32'(gnt), 0);
    step();

    // Fixed priority: last winner was qcpu, yet qcpu still takes the conflict
    prio_fixed = 1'b1; req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      check("fp_gnt", 32'(gnt), (k % 2 == 0) ? 'h1 : 'h2);
    end
    req = 2'b00; step(); step();
    prio_fixed = 1'b0;

    // Disabled requester is ignored; a clear after arbitration keeps the read
    en = 2'b10; req[0] = 1'b1; addr[0] = 6'h05;
    for (int k = 0; k < 3; k++) begin
      step();
      check("en_no_gnt", 32'(gnt), 0);
    end
    en = 2'b11; step();
    check("en_gnt", 32'(gnt), 'h1);
    en = 2'b10; req[0] = 1'b0; step();
    check("en_rvalid", 32'(rvalid), 'h1);
    check("en_rdata0", 32'(rdata[0]), 'hA5);
    en = 2'b11; step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
